// File: rtl/conv_ram_loader_if.sv
// ---------------------------------------------------------------------------
// conv_ram_loader_if
// Purpose : valid/ready word stream feeding the conv RAM loader.
// Signals : s_valid  - producer has a word on s_data
//           s_ready  - consumer accepts the word this cycle
//           s_data   - stream word (DATA_W bits)
// Modports: master drives valid/data, slave drives ready.
// ---------------------------------------------------------------------------
interface conv_ram_loader_if #(
   parameter int DATA_W = 128
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/conv_ram_loader.sv
// ---------------------------------------------------------------------------
// conv_ram_loader
// Purpose : multi-layer loader for the conv layer. Streams image words into
//           the image RAM and weight words into the weight RAM, fires a
//           convStart pulse, waits for convFinish and repeats per layer.
//           In image-reuse mode only weights are reloaded after layer 0.
// Ports   : clk, rst_n            clock / async active-low reset
//           start_i, abort_i      job start pulse / synchronous abort
//           cfg_*_i               job configuration, latched on start
//           s_if (slave)          input word stream
//           convFinish_i          conv layer done pulse
//           cnn_state_o           loader phase (IDLE=0 .. DONE=5)
//           convStart_o           one-cycle conv start pulse
//           W_o/H_o/C_o           latched dimensions
//           ramImage_*_o          image RAM write port
//           ramWeight_*_o         weight RAM write port
//           layer_idx_o           current layer, 0-based
//           cfg_err_o, done_o     rejected-start pulse / job-complete pulse
// ---------------------------------------------------------------------------
module conv_ram_loader #(
   parameter int DATA_W     = 128,
   parameter int IMG_AW     = 10,
   parameter int WT_AW      = 5,
   parameter int DIM_BITS   = 6,
   parameter int CH_BITS    = 5,
   parameter int LAYER_BITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [DIM_BITS-1:0]   cfg_W_i,
   input  logic [DIM_BITS-1:0]   cfg_H_i,
   input  logic [CH_BITS-1:0]    cfg_C_i,
   input  logic [WT_AW:0]        cfg_wt_words_i,
   input  logic [LAYER_BITS-1:0] cfg_layers_i,
   input  logic                  cfg_reuse_img_i,
   conv_ram_loader_if.slave      s_if,
   input  logic                  convFinish_i,
   output logic [2:0]            cnn_state_o,
   output logic                  convStart_o,
   output logic [DIM_BITS-1:0]   W_o,
   output logic [DIM_BITS-1:0]   H_o,
   output logic [CH_BITS-1:0]    C_o,
   output logic                  ramImage_en_o,
   output logic                  ramImage_we_o,
   output logic [IMG_AW-1:0]     ramImage_addrW_o,
   output logic [DATA_W-1:0]     ramImage_din_o,
   output logic                  ramWeight_en_o,
   output logic                  ramWeight_we_o,
   output logic [WT_AW-1:0]      ramWeight_addrW_o,
   output logic [DATA_W-1:0]     ramWeight_din_o,
   output logic [LAYER_BITS-1:0] layer_idx_o,
   output logic                  cfg_err_o,
   output logic                  done_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LD_IMG = 3'd1,
      S_LD_WT  = 3'd2,
      S_CSTART = 3'd3,
      S_WAIT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam int PROD_W  = 2 * DIM_BITS;
   localparam int IMG_CAP = 1 << IMG_AW;
   localparam int WT_CAP  = 1 << WT_AW;
   localparam logic [IMG_AW:0]       IMG_ONE = {{IMG_AW{1'b0}}, 1'b1};
   localparam logic [WT_AW:0]        WT_ONE  = {{WT_AW{1'b0}}, 1'b1};
   localparam logic [LAYER_BITS-1:0] LAY_ONE = {{(LAYER_BITS-1){1'b0}}, 1'b1};

   state_t                  state_q;
   logic [IMG_AW:0]         npix_q;
   logic [IMG_AW:0]         img_cnt_q;
   logic [WT_AW:0]          nwt_q;
   logic [WT_AW:0]          wt_cnt_q;
   logic [LAYER_BITS-1:0]   layers_q;
   logic [LAYER_BITS-1:0]   layer_q;
   logic                    reuse_q;
   logic                    conv_start_q;
   logic                    done_q;
   logic                    cfg_err_q;
   logic [DIM_BITS-1:0]     w_q;
   logic [DIM_BITS-1:0]     h_q;
   logic [CH_BITS-1:0]      c_q;
   logic                    img_wr_q;
   logic [IMG_AW-1:0]       img_addr_q;
   logic [DATA_W-1:0]       img_din_q;
   logic                    wt_wr_q;
   logic [WT_AW-1:0]        wt_addr_q;
   logic [DATA_W-1:0]       wt_din_q;

   logic [PROD_W-1:0]       pix_prod_d;
   logic                    cfg_ok_d;
   logic                    xfer_d;

   // ready is a pure decode of the registered state
   assign s_if.s_ready = (state_q == S_LD_IMG) || (state_q == S_LD_WT);

   // start validation and stream transfer detection
   always_comb begin
      pix_prod_d = PROD_W'(cfg_W_i) * PROD_W'(cfg_H_i);
      xfer_d     = s_if.s_valid & s_if.s_ready;
      // pixel count compared at full product width so 32x33 cannot alias
      cfg_ok_d   = (cfg_W_i != '0) && (cfg_H_i != '0) && (cfg_C_i != '0) &&
                   (cfg_wt_words_i != '0) && (cfg_layers_i != '0) &&
                   (int'(cfg_C_i) <= 32'sd16) &&
                   (int'(pix_prod_d) <= IMG_CAP) &&
                   (int'(cfg_wt_words_i) <= WT_CAP);
   end

   // loader FSM, counters and registered RAM write ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         npix_q       <= '0;
         img_cnt_q    <= '0;
         nwt_q        <= '0;
         wt_cnt_q     <= '0;
         layers_q     <= '0;
         layer_q      <= '0;
         reuse_q      <= 1'b0;
         conv_start_q <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         w_q          <= '0;
         h_q          <= '0;
         c_q          <= '0;
         img_wr_q     <= 1'b0;
         img_addr_q   <= '0;
         img_din_q    <= '0;
         wt_wr_q      <= 1'b0;
         wt_addr_q    <= '0;
         wt_din_q     <= '0;
      end else begin
         conv_start_q <= 1'b0;
         done_q       <= 1'b0;
         cfg_err_q    <= 1'b0;
         img_wr_q     <= 1'b0;
         wt_wr_q      <= 1'b0;

         // an accepted word is always written, even in an abort cycle
         if (xfer_d && (state_q == S_LD_IMG)) begin
            img_wr_q   <= 1'b1;
            img_addr_q <= img_cnt_q[IMG_AW-1:0];
            img_din_q  <= s_if.s_data;
         end
         if (xfer_d && (state_q == S_LD_WT)) begin
            wt_wr_q   <= 1'b1;
            wt_addr_q <= wt_cnt_q[WT_AW-1:0];
            wt_din_q  <= s_if.s_data;
         end

         if (abort_i) begin
            state_q   <= S_IDLE;
            img_cnt_q <= '0;
            wt_cnt_q  <= '0;
            layer_q   <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start_i) begin
                     if (cfg_ok_d) begin
                        w_q       <= cfg_W_i;
                        h_q       <= cfg_H_i;
                        c_q       <= cfg_C_i;
                        npix_q    <= (IMG_AW+1)'(pix_prod_d);
                        nwt_q     <= cfg_wt_words_i;
                        layers_q  <= cfg_layers_i;
                        reuse_q   <= cfg_reuse_img_i;
                        layer_q   <= '0;
                        img_cnt_q <= '0;
                        wt_cnt_q  <= '0;
                        state_q   <= S_LD_IMG;
                     end else begin
                        cfg_err_q <= 1'b1;
                     end
                  end
               end
               S_LD_IMG: begin
                  if (xfer_d) begin
                     if (img_cnt_q + IMG_ONE == npix_q) begin
                        img_cnt_q <= '0;
                        state_q   <= S_LD_WT;
                     end else begin
                        img_cnt_q <= img_cnt_q + IMG_ONE;
                     end
                  end
               end
               S_LD_WT: begin
                  if (xfer_d) begin
                     if (wt_cnt_q + WT_ONE == nwt_q) begin
                        wt_cnt_q     <= '0;
                        conv_start_q <= 1'b1;  // visible exactly while in CSTART
                        state_q      <= S_CSTART;
                     end else begin
                        wt_cnt_q <= wt_cnt_q + WT_ONE;
                     end
                  end
               end
               S_CSTART: begin
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (convFinish_i) begin
                     if (layer_q == layers_q - LAY_ONE) begin
                        done_q  <= 1'b1;       // visible exactly while in DONE
                        state_q <= S_DONE;
                     end else begin
                        layer_q <= layer_q + LAY_ONE;
                        state_q <= reuse_q ? S_LD_WT : S_LD_IMG;
                     end
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign cnn_state_o       = state_q;
   assign convStart_o       = conv_start_q;
   assign done_o            = done_q;
   assign cfg_err_o         = cfg_err_q;
   assign W_o               = w_q;
   assign H_o               = h_q;
   assign C_o               = c_q;
   assign layer_idx_o       = layer_q;
   assign ramImage_en_o     = img_wr_q;
   assign ramImage_we_o     = img_wr_q;
   assign ramImage_addrW_o  = img_addr_q;
   assign ramImage_din_o    = img_din_q;
   assign ramWeight_en_o    = wt_wr_q;
   assign ramWeight_we_o    = wt_wr_q;
   assign ramWeight_addrW_o = wt_addr_q;
   assign ramWeight_din_o   = wt_din_q;

endmodule

// File: tb/tb_conv_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_conv_ram_loader
// Bench for conv_ram_loader. A job-level model lists, in order, every RAM
// write (kind + address) and every convStart (write count + layer) a job
// must produce; the k-th write overall must carry the k-th accepted stream
// word. A monitor compares each cycle against that list.
// ---------------------------------------------------------------------------
module tb_conv_ram_loader;

   localparam int MODE_NORM  = 0;
   localparam int MODE_ABORT = 1;
   localparam int MODE_RST   = 2;
   localparam int MODE_NOISE = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, abort, cfg_reuse, convFinish;
   logic [5:0]   cfg_W, cfg_H;
   logic [4:0]   cfg_C;
   logic [5:0]   cfg_wt;
   logic [2:0]   cfg_layers;
   logic [2:0]   cnn_state;
   logic         convStart, img_en, img_we, wt_en, wt_we, cfg_err, done;
   logic [5:0]   W, H;
   logic [4:0]   C;
   logic [9:0]   img_addr;
   logic [4:0]   wt_addr;
   logic [127:0] img_din, wt_din;
   logic [2:0]   layer_idx;

   conv_ram_loader_if #(.DATA_W(128)) sif ();

   conv_ram_loader dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
      .cfg_W_i(cfg_W), .cfg_H_i(cfg_H), .cfg_C_i(cfg_C),
      .cfg_wt_words_i(cfg_wt), .cfg_layers_i(cfg_layers),
      .cfg_reuse_img_i(cfg_reuse), .s_if(sif), .convFinish_i(convFinish),
      .cnn_state_o(cnn_state), .convStart_o(convStart),
      .W_o(W), .H_o(H), .C_o(C),
      .ramImage_en_o(img_en), .ramImage_we_o(img_we),
      .ramImage_addrW_o(img_addr), .ramImage_din_o(img_din),
      .ramWeight_en_o(wt_en), .ramWeight_we_o(wt_we),
      .ramWeight_addrW_o(wt_addr), .ramWeight_din_o(wt_din),
      .layer_idx_o(layer_idx), .cfg_err_o(cfg_err), .done_o(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [127:0] word_of(input int k);
      logic [31:0] u;
      u = k;
      return {u ^ 32'hC0DE_0000, u * 32'd7 + 32'd3, ~u, u};
   endfunction

   // ---- job-level model ----
   typedef struct { bit img; int addr; } wr_t;
   wr_t exp_q[$];
   int  conv_q[$];
   int  lay_q[$];

   int sent = 0, wr_cnt = 0, img_wr = 0, wt_wr = 0;
   int cs_cnt = 0, done_cnt = 0, err_cnt = 0;
   int last_img = -1, last_wt = -1;

   function automatic void build_model(input int w, h, wt, ly, input bit reuse);
      int n;
      n = wr_cnt;
      for (int l = 0; l < ly; l++) begin
         if (l == 0 || !reuse)
            for (int a = 0; a < w * h; a++) begin
               exp_q.push_back('{1'b1, a}); n++;
            end
         for (int a = 0; a < wt; a++) begin
            exp_q.push_back('{1'b0, a}); n++;
         end
         conv_q.push_back(n);
         lay_q.push_back(l);
      end
   endfunction

   function automatic void flush_model();
      exp_q.delete(); conv_q.delete(); lay_q.delete();
   endfunction

   // ---- per-cycle monitor, sampled 1 time unit after the rising edge ----
   initial begin
      wr_t  it;
      logic xfer;
      forever begin
         @(posedge clk);
         xfer = rst_n && sif.s_valid && sif.s_ready;
         #1;
         if (xfer) sent++;
         if (!rst_n) begin
            wr_cnt = sent;
         end else begin
            chk(img_en === img_we, "img_en_eq_we", img_en, img_we);
            chk(wt_en === wt_we, "wt_en_eq_we", wt_en, wt_we);
            chk(sif.s_ready === (cnn_state == 3'd1 || cnn_state == 3'd2),
                "s_ready_phase", sif.s_ready, cnn_state);
            if (img_en) begin
               if (exp_q.size() == 0) chk(1'b0, "img_unexpected", img_addr, 0);
               else begin
                  it = exp_q.pop_front();
                  chk(it.img, "img_kind", 1, it.img);
                  chk(int'(img_addr) == it.addr, "img_addr", img_addr, it.addr);
                  chk(img_din === word_of(wr_cnt), "img_din", img_din, word_of(wr_cnt));
               end
               wr_cnt++; img_wr++; last_img = int'(img_addr);
            end
            if (wt_en) begin
               if (exp_q.size() == 0) chk(1'b0, "wt_unexpected", wt_addr, 0);
               else begin
                  it = exp_q.pop_front();
                  chk(!it.img, "wt_kind", 0, it.img);
                  chk(int'(wt_addr) == it.addr, "wt_addr", wt_addr, it.addr);
                  chk(wt_din === word_of(wr_cnt), "wt_din", wt_din, word_of(wr_cnt));
               end
               wr_cnt++; wt_wr++; last_wt = int'(wt_addr);
            end
            if (convStart) begin
               cs_cnt++;
               chk(cnn_state == 3'd3, "cstart_state", cnn_state, 3);
               if (conv_q.size() == 0) chk(1'b0, "cstart_unexpected", cs_cnt, 0);
               else begin
                  chk(wr_cnt == conv_q[0], "cstart_after_writes", wr_cnt, conv_q[0]);
                  chk(int'(layer_idx) == lay_q[0], "cstart_layer", layer_idx, lay_q[0]);
                  void'(conv_q.pop_front());
                  void'(lay_q.pop_front());
               end
            end
            if (done) begin
               done_cnt++;
               chk(cnn_state == 3'd5, "done_state", cnn_state, 5);
               chk(conv_q.size() == 0 && exp_q.size() == 0, "done_model_drained",
                   exp_q.size() + conv_q.size(), 0);
            end
            if (cfg_err) err_cnt++;
         end
      end
   end

   task automatic set_cfg(input int w, h, c, wt, ly, input bit reuse);
      cfg_W = 6'(w); cfg_H = 6'(h); cfg_C = 5'(c);
      cfg_wt = 6'(wt); cfg_layers = 3'(ly); cfg_reuse = reuse;
   endtask

   function automatic bit outs_zero();
      return (cnn_state == 3'd0) && !convStart && (W == 6'd0) && (H == 6'd0) &&
             (C == 5'd0) && !img_en && !img_we && (img_addr == 10'd0) &&
             (img_din == 128'd0) && !wt_en && !wt_we && (wt_addr == 5'd0) &&
             (wt_din == 128'd0) && (layer_idx == 3'd0) && !cfg_err && !done &&
             !sif.s_ready;
   endfunction

   task automatic run_job(input int w, h, c, wt, ly, input bit reuse,
                          input bit rnd, input int mode);
      int cyc, wait_cyc, s0, d0, keep;
      bit noise_img, noise_wait;
      build_model(w, h, wt, ly, reuse);
      d0 = done_cnt; s0 = sent;
      noise_img = 1'b0; noise_wait = 1'b0;
      @(negedge clk);
      set_cfg(w, h, c, wt, ly, reuse);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0; wait_cyc = 0;
      while (done_cnt == d0 && cyc < 20000) begin
         sif.s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         sif.s_data  = word_of(sent);
         convFinish  = 1'b0;
         start       = 1'b0;
         if (cnn_state == 3'd4) begin
            wait_cyc++;
            if (wait_cyc == 3) begin convFinish = 1'b1; wait_cyc = 0; end
         end else wait_cyc = 0;
         if (mode == MODE_NOISE) begin
            if (cnn_state == 3'd1 && !noise_img) begin convFinish = 1'b1; noise_img = 1'b1; end
            if (cnn_state == 3'd3) convFinish = 1'b1;
            if (cnn_state == 3'd4 && !noise_wait) begin start = 1'b1; noise_wait = 1'b1; end
         end
         if (mode == MODE_ABORT && sent - s0 == w * h + 4) begin
            chk(cnn_state == 3'd2, "abort_in_ld_wt", cnn_state, 2);
            abort = 1'b1; sif.s_valid = 1'b0;
            @(negedge clk);
            abort = 1'b0;
            chk(cnn_state == 3'd0, "abort_to_idle", cnn_state, 0);
            chk(sif.s_ready == 1'b0, "abort_s_ready", sif.s_ready, 0);
            keep = cs_cnt;
            repeat (6) @(negedge clk);
            chk(cs_cnt == keep && done_cnt == d0, "abort_no_cstart_done", cs_cnt, keep);
            chk(cnn_state == 3'd0, "abort_stays_idle", cnn_state, 0);
            flush_model();
            return;
         end
         if (mode == MODE_RST && cnn_state == 3'd1 && sent - s0 == 5) begin
            rst_n = 1'b0;
            #1;
            chk(outs_zero(), "reset_mid_ld_img", {W, H, C, cnn_state, img_addr}, 0);
            flush_model();
            repeat (2) @(negedge clk);
            sif.s_valid = 1'b0;
            rst_n = 1'b1;
            repeat (6) @(negedge clk);
            chk(outs_zero(), "reset_release_quiet", {cnn_state, img_addr}, 0);
            return;
         end
         @(negedge clk);
         cyc++;
      end
      sif.s_valid = 1'b0; convFinish = 1'b0; start = 1'b0;
      chk(done_cnt == d0 + 1, "job_done", done_cnt - d0, 1);
      chk(exp_q.size() == 0 && conv_q.size() == 0, "job_model_drained",
          exp_q.size() + conv_q.size(), 0);
      repeat (3) @(negedge clk);
      chk(done_cnt == d0 + 1 && cnn_state == 3'd0, "job_single_done", done_cnt - d0, 1);
   endtask

   task automatic reject(input int w, h, c, wt, ly);
      int e0;
      e0 = err_cnt;
      @(negedge clk);
      set_cfg(w, h, c, wt, ly, 1'b0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk(cfg_err == 1'b1, "cfg_err_pulse", cfg_err, 1);
      @(negedge clk);
      chk(cfg_err == 1'b0, "cfg_err_one_cycle", cfg_err, 0);
      chk(cnn_state == 3'd0, "reject_stays_idle", cnn_state, 0);
      chk(err_cnt == e0 + 1, "cfg_err_count", err_cnt - e0, 1);
   endtask

   initial begin
      int i0, w0, c0, d0, e0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; convFinish = 1'b0;
      sif.s_valid = 1'b0; sif.s_data = '0;
      set_cfg(0, 0, 0, 0, 0, 1'b0);
      repeat (3) @(negedge clk);
      chk(outs_zero(), "reset_state", {W, H, C, cnn_state, img_addr}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 4x4, 9 weights, one layer, continuous valid
      i0 = img_wr; w0 = wt_wr; c0 = cs_cnt; d0 = done_cnt;
      run_job(4, 4, 3, 9, 1, 1'b0, 1'b0, MODE_NORM);
      chk(img_wr - i0 == 16, "t1_img_writes", img_wr - i0, 16);
      chk(wt_wr - w0 == 9, "t1_wt_writes", wt_wr - w0, 9);
      chk(last_img == 15 && last_wt == 8, "t1_last_addrs", {last_img, last_wt}, {32'd15, 32'd8});
      chk(cs_cnt - c0 == 1 && done_cnt - d0 == 1, "t1_cstart_done", cs_cnt - c0, 1);
      chk(W == 6'd4 && H == 6'd4 && C == 5'd3, "t1_whc", {W, H, C}, {6'd4, 6'd4, 5'd3});

      // 2: full 32x32 image accepted, then oversize configs rejected
      i0 = img_wr;
      run_job(32, 32, 16, 1, 1, 1'b0, 1'b0, MODE_NORM);
      chk(img_wr - i0 == 1024, "t2_img_writes", img_wr - i0, 1024);
      chk(last_img == 1023, "t2_last_img_addr", last_img, 1023);
      reject(32, 33, 3, 9, 1);
      reject(4, 4, 17, 9, 1);
      reject(4, 4, 3, 33, 1);
      chk(W == 6'd32 && H == 6'd32 && C == 5'd16, "t2_whc_hold", {W, H, C}, {6'd32, 6'd32, 5'd16});

      // 3: three layers with and without image reuse
      i0 = img_wr; w0 = wt_wr; c0 = cs_cnt; d0 = done_cnt;
      run_job(4, 4, 3, 9, 3, 1'b1, 1'b0, MODE_NORM);
      chk(img_wr - i0 == 16 && wt_wr - w0 == 27, "t3_reuse_counts",
          {img_wr - i0, wt_wr - w0}, {32'd16, 32'd27});
      chk(cs_cnt - c0 == 3 && done_cnt - d0 == 1, "t3_reuse_cstarts", cs_cnt - c0, 3);
      i0 = img_wr;
      run_job(4, 4, 3, 9, 3, 1'b0, 1'b0, MODE_NORM);
      chk(img_wr - i0 == 48, "t3_noreuse_img", img_wr - i0, 48);

      // 4: random 50% valid, 5x3 image, 6 weights, 2 layers
      i0 = img_wr; w0 = wt_wr;
      run_job(5, 3, 7, 6, 2, 1'b0, 1'b1, MODE_NORM);
      chk(img_wr - i0 == 30 && wt_wr - w0 == 12, "t4_rand_counts",
          {img_wr - i0, wt_wr - w0}, {32'd30, 32'd12});

      // 5: abort at weight word 4, then a fresh job starts at address 0
      c0 = cs_cnt;
      run_job(4, 4, 3, 9, 1, 1'b0, 1'b0, MODE_ABORT);
      chk(cs_cnt == c0, "t5_no_cstart", cs_cnt - c0, 0);
      i0 = img_wr;
      run_job(4, 4, 3, 9, 1, 1'b0, 1'b0, MODE_NORM);
      chk(img_wr - i0 == 16, "t5_reload_img", img_wr - i0, 16);

      // 6: stray convFinish / start are ignored; reset mid-load
      c0 = cs_cnt; d0 = done_cnt; e0 = err_cnt;
      run_job(4, 4, 3, 9, 2, 1'b0, 1'b0, MODE_NOISE);
      chk(cs_cnt - c0 == 2 && done_cnt - d0 == 1, "t6_noise_flow", cs_cnt - c0, 2);
      chk(err_cnt == e0, "t6_no_cfg_err", err_cnt - e0, 0);
      run_job(4, 4, 3, 9, 1, 1'b0, 1'b0, MODE_RST);
      run_job(2, 2, 1, 3, 1, 1'b0, 1'b0, MODE_NORM);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
